tlb_refill_walker: RTL and testbench

TLB_REFILL_WALKER -- requirements
Module: tlb_refill_walker

---
 rtl/tlb_refill_walker_pkg.sv | 17 +
 rtl/tlb_refill_walker_sat_counter.sv | 23 ++
 rtl/tlb_refill_walker.sv | 117 +++++++++++
 tb/tb_tlb_refill_walker.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/tlb_refill_walker_pkg.sv
// Shared TLB walker definitions: default geometry, PTE layout and walker state encoding.
package tlb_refill_walker_pkg;

  localparam int unsigned TLB_OFFSET         = 12;
  localparam int unsigned TLB_PHYS_ADDR_SIZE = 24;
  localparam int unsigned PTE_VALID_BIT      = 31;
  localparam int unsigned REFILL_COUNT_W     = 16;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    WAIT  = 3'd2,
    FILL  = 3'd3,
    FAULT = 3'd4
  } walk_state_e;

endpackage

// File: rtl/tlb_refill_walker_sat_counter.sv
// Saturating up-counter: holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_q;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      count_q <= '0;
    end else if (inc && (count_q != '1)) begin
      count_q <= count_q + 1'b1;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/tlb_refill_walker.sv
// Single-level page-table walker: on a TLB miss fetch the PTE, then refill the TLB or raise a page fault.
module tlb_refill_walker
  import tlb_refill_walker_pkg::*;
#(
  parameter int unsigned OFFSET         = TLB_OFFSET,
  parameter int unsigned PHYS_ADDR_SIZE = TLB_PHYS_ADDR_SIZE
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic                      tlb_miss_i,
  input  logic [31:0]               virtual_address_i,
  input  logic [PHYS_ADDR_SIZE-1:0] ptbr_i,
  output logic                      mem_req_o,
  output logic [PHYS_ADDR_SIZE-1:0] mem_addr_o,
  input  logic                      mem_ready_i,
  input  logic [31:0]               mem_data_i,
  output logic [31-OFFSET:0]        w_virtual_page_o,
  output logic [31-OFFSET:0]        w_phys_page_o,
  output logic                      write_enable_o,
  output logic                      stall_o,
  output logic                      page_fault_o,
  output logic [31-OFFSET:0]        fault_vpn_o,
  output logic [15:0]               refill_count_o
);

  localparam int unsigned VPN_W = 32 - OFFSET;
  localparam int unsigned PPN_W = PHYS_ADDR_SIZE - OFFSET;

  walk_state_e      state_q, state_d;
  logic [VPN_W-1:0] vpn_q;
  logic [VPN_W-1:0] fault_vpn_q;
  logic [PPN_W-1:0] ppn_q;
  logic             unused_bits;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      vpn_q       <= '0;
      ppn_q       <= '0;
      fault_vpn_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && tlb_miss_i) begin
        vpn_q <= virtual_address_i[31:OFFSET];
      end
      // Fault VPN loads on entry to FAULT so it is already valid during the pulse.
      if (state_q == WAIT && mem_ready_i) begin
        ppn_q <= mem_data_i[PPN_W-1:0];
        if (!mem_data_i[PTE_VALID_BIT]) begin
          fault_vpn_q <= vpn_q;
        end
      end
    end
  end

  always_comb begin
    state_d        = state_q;
    mem_req_o      = 1'b0;
    write_enable_o = 1'b0;
    page_fault_o   = 1'b0;
    stall_o        = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (tlb_miss_i) begin
          stall_o = 1'b1;
          state_d = REQ;
        end
      end
      REQ: begin
        stall_o   = 1'b1;
        mem_req_o = 1'b1;
        state_d   = WAIT;
      end
      WAIT: begin
        stall_o   = 1'b1;
        mem_req_o = 1'b1;
        if (mem_ready_i) begin
          state_d = mem_data_i[PTE_VALID_BIT] ? FILL : FAULT;
        end
      end
      FILL: begin
        stall_o        = 1'b1;
        write_enable_o = 1'b1;
        state_d        = IDLE;
      end
      FAULT: begin
        stall_o      = 1'b1;
        page_fault_o = 1'b1;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Reset is synchronous, so strobes are gated combinationally while it is held.
    if (!reset_n) begin
      mem_req_o      = 1'b0;
      write_enable_o = 1'b0;
      page_fault_o   = 1'b0;
      stall_o        = 1'b0;
    end
  end

  assign mem_addr_o       = ptbr_i + PHYS_ADDR_SIZE'({vpn_q, 2'b00});
  assign w_virtual_page_o = vpn_q;
  assign w_phys_page_o    = VPN_W'(ppn_q);
  assign fault_vpn_o      = fault_vpn_q;
  assign unused_bits      = ^{mem_data_i[PTE_VALID_BIT-1:PPN_W], virtual_address_i[OFFSET-1:0]};

  sat_counter #(
    .WIDTH(REFILL_COUNT_W)
  ) u_refill_cnt (
    .clock   (clock),
    .reset_n (reset_n),
    .inc     (state_q == FILL),
    .count   (refill_count_o)
  );

endmodule

// File: tb/tb_tlb_refill_walker.sv
// Directed bench for tlb_refill_walker: vector table plus multi-cycle corner sequences.
module tb_tlb_refill_walker;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        tlb_miss_i;
  logic [31:0] virtual_address_i;
  logic [23:0] ptbr_i;
  logic        mem_req_o;
  logic [23:0] mem_addr_o;
  logic        mem_ready_i;
  logic [31:0] mem_data_i;
  logic [19:0] w_virtual_page_o;
  logic [19:0] w_phys_page_o;
  logic        write_enable_o;
  logic        stall_o;
  logic        page_fault_o;
  logic [19:0] fault_vpn_o;
  logic [15:0] refill_count_o;

  int unsigned n_pass  = 0;
  int unsigned n_total = 0;

  tlb_refill_walker #(
    .OFFSET         (12),
    .PHYS_ADDR_SIZE (24)
  ) dut (
    .clock             (clock),
    .reset_n           (reset_n),
    .tlb_miss_i        (tlb_miss_i),
    .virtual_address_i (virtual_address_i),
    .ptbr_i            (ptbr_i),
    .mem_req_o         (mem_req_o),
    .mem_addr_o        (mem_addr_o),
    .mem_ready_i       (mem_ready_i),
    .mem_data_i        (mem_data_i),
    .w_virtual_page_o  (w_virtual_page_o),
    .w_phys_page_o     (w_phys_page_o),
    .write_enable_o    (write_enable_o),
    .stall_o           (stall_o),
    .page_fault_o      (page_fault_o),
    .fault_vpn_o       (fault_vpn_o),
    .refill_count_o    (refill_count_o)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        rst_n;
    logic        miss;
    logic [31:0] va;
    logic [23:0] ptbr;
    logic        ready;
    logic [31:0] data;
    logic        e_req;
    logic [23:0] e_addr;
    logic        e_we;
    logic [19:0] e_wvp;
    logic [19:0] e_wpp;
    logic        e_stall;
    logic        e_pf;
    logic [19:0] e_fvpn;
    logic [15:0] e_cnt;
  } vec_t;

  vec_t vecs[18];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    else n_pass++;
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Counts cycles (current one = 0) until write_enable_o is seen, bounded.
  task automatic wait_we(input string name, output int lat);
    lat = 0;
    forever begin
      #1;
      if (write_enable_o === 1'b1) break;
      if (lat >= 20) begin
        n_total++;
        $display("FAIL %s: no write_enable within 20 cycles", name);
        break;
      end
      step();
      lat++;
    end
  endtask

  initial begin
    int lat;
    int we_cnt;
    logic stall_ok;
    logic [19:0] wpp_seen;
    logic seen_any;

    // rst miss va ptbr ready data | req addr we wvp wpp stall pf fvpn cnt
    vecs[0]  = '{0, 1, 32'h3ABC, 24'h001000, 0, 32'h0,        0, 24'h001000, 0, 20'h0, 20'h0,   0, 0, 20'h0, 16'd0};
    vecs[1]  = '{1, 1, 32'h3ABC, 24'h001000, 0, 32'h0,        0, 24'h001000, 0, 20'h0, 20'h0,   1, 0, 20'h0, 16'd0};
    vecs[2]  = '{1, 0, 32'h0,    24'h001000, 0, 32'h0,        1, 24'h00100C, 0, 20'h3, 20'h0,   1, 0, 20'h0, 16'd0};
    vecs[3]  = '{1, 0, 32'h0,    24'h001000, 0, 32'h0,        1, 24'h00100C, 0, 20'h3, 20'h0,   1, 0, 20'h0, 16'd0};
    vecs[4]  = '{1, 0, 32'h0,    24'h001000, 0, 32'h0,        1, 24'h00100C, 0, 20'h3, 20'h0,   1, 0, 20'h0, 16'd0};
    vecs[5]  = '{1, 0, 32'h0,    24'h001000, 1, 32'h80000055, 1, 24'h00100C, 0, 20'h3, 20'h0,   1, 0, 20'h0, 16'd0};
    vecs[6]  = '{1, 0, 32'h0,    24'h001000, 0, 32'h0,        0, 24'h00100C, 1, 20'h3, 20'h55,  1, 0, 20'h0, 16'd0};
    vecs[7]  = '{1, 0, 32'h0,    24'h001000, 1, 32'h80000099, 0, 24'h00100C, 0, 20'h3, 20'h55,  0, 0, 20'h0, 16'd1};
    vecs[8]  = '{1, 1, 32'h7000, 24'h001000, 0, 32'h0,        0, 24'h00100C, 0, 20'h3, 20'h55,  1, 0, 20'h0, 16'd1};
    vecs[9]  = '{1, 0, 32'h0,    24'h001000, 0, 32'h0,        1, 24'h00101C, 0, 20'h7, 20'h55,  1, 0, 20'h0, 16'd1};
    vecs[10] = '{1, 0, 32'h0,    24'h001000, 1, 32'h00000055, 1, 24'h00101C, 0, 20'h7, 20'h55,  1, 0, 20'h0, 16'd1};
    vecs[11] = '{1, 0, 32'h0,    24'h001000, 0, 32'h0,        0, 24'h00101C, 0, 20'h7, 20'h55,  1, 1, 20'h7, 16'd1};
    vecs[12] = '{1, 0, 32'h0,    24'h001000, 0, 32'h0,        0, 24'h00101C, 0, 20'h7, 20'h55,  0, 0, 20'h7, 16'd1};
    vecs[13] = '{1, 1, 32'h2000, 24'hFFFFFC, 0, 32'h0,        0, 24'h000018, 0, 20'h7, 20'h55,  1, 0, 20'h7, 16'd1};
    vecs[14] = '{1, 0, 32'h0,    24'hFFFFFC, 0, 32'h0,        1, 24'h000004, 0, 20'h2, 20'h55,  1, 0, 20'h7, 16'd1};
    vecs[15] = '{1, 0, 32'h0,    24'hFFFFFC, 1, 32'h80000123, 1, 24'h000004, 0, 20'h2, 20'h55,  1, 0, 20'h7, 16'd1};
    vecs[16] = '{1, 0, 32'h0,    24'hFFFFFC, 0, 32'h0,        0, 24'h000004, 1, 20'h2, 20'h123, 1, 0, 20'h7, 16'd1};
    vecs[17] = '{1, 0, 32'h0,    24'hFFFFFC, 0, 32'h0,        0, 24'h000004, 0, 20'h2, 20'h123, 0, 0, 20'h7, 16'd2};

    reset_n = 1'b0; tlb_miss_i = 1'b0; virtual_address_i = '0;
    ptbr_i = 24'h001000; mem_ready_i = 1'b0; mem_data_i = '0;
    step();
    step();

    for (int i = 0; i < 18; i++) begin
      reset_n           = vecs[i].rst_n;
      tlb_miss_i        = vecs[i].miss;
      virtual_address_i = vecs[i].va;
      ptbr_i            = vecs[i].ptbr;
      mem_ready_i       = vecs[i].ready;
      mem_data_i        = vecs[i].data;
      #1;
      chk($sformatf("v%0d.mem_req", i),   32'(mem_req_o),        32'(vecs[i].e_req));
      chk($sformatf("v%0d.mem_addr", i),  32'(mem_addr_o),       32'(vecs[i].e_addr));
      chk($sformatf("v%0d.we", i),        32'(write_enable_o),   32'(vecs[i].e_we));
      chk($sformatf("v%0d.wvp", i),       32'(w_virtual_page_o), 32'(vecs[i].e_wvp));
      chk($sformatf("v%0d.wpp", i),       32'(w_phys_page_o),    32'(vecs[i].e_wpp));
      chk($sformatf("v%0d.stall", i),     32'(stall_o),          32'(vecs[i].e_stall));
      chk($sformatf("v%0d.pf", i),        32'(page_fault_o),     32'(vecs[i].e_pf));
      chk($sformatf("v%0d.fault_vpn", i), 32'(fault_vpn_o),      32'(vecs[i].e_fvpn));
      chk($sformatf("v%0d.count", i),     32'(refill_count_o),   32'(vecs[i].e_cnt));
      step();
    end

    // Second miss pulse while waiting on memory must not start another walk.
    ptbr_i = 24'h001000; we_cnt = 0; stall_ok = 1'b1; wpp_seen = '0;
    for (int c = 0; c < 12; c++) begin
      tlb_miss_i        = (c == 0) || (c == 3);
      virtual_address_i = 32'h0000_5000;
      mem_ready_i       = (c == 5);
      mem_data_i        = 32'h8000_0077;
      #1;
      if (c <= 6 && stall_o !== 1'b1) stall_ok = 1'b0;
      if (write_enable_o === 1'b1) begin
        we_cnt++;
        wpp_seen = w_phys_page_o;
      end
      step();
    end
    tlb_miss_i = 1'b0; mem_ready_i = 1'b0;
    #1;
    chk("dup_miss.stall_held", 32'(stall_ok), 32'd1);
    chk("dup_miss.we_count",   32'(we_cnt),   32'd1);
    chk("dup_miss.wpp",        32'(wpp_seen), 32'h77);
    chk("dup_miss.count",      32'(refill_count_o), 32'd3);
    chk("dup_miss.idle_req",   32'(mem_req_o), 32'd0);
    step();

    // Zero-wait latency with ready held high everywhere; miss kept high to chain a second walk.
    tlb_miss_i = 1'b1; virtual_address_i = 32'h0000_6000;
    mem_ready_i = 1'b1; mem_data_i = 32'h8000_0011;
    wait_we("latency", lat);
    chk("latency.cycles", 32'(lat), 32'd3);
    chk("latency.wpp",    32'(w_phys_page_o), 32'h11);
    step();
    #1;
    chk("rewalk.idle_stall", 32'(stall_o),   32'd1);
    chk("rewalk.idle_req",   32'(mem_req_o), 32'd0);
    step();
    #1;
    chk("rewalk.req", 32'(mem_req_o), 32'd1);
    tlb_miss_i = 1'b0;
    wait_we("rewalk", lat);
    step();
    #1;
    chk("rewalk.count", 32'(refill_count_o), 32'd5);

    // Reset during WAIT, then a late ready.
    mem_ready_i = 1'b0; tlb_miss_i = 1'b1; virtual_address_i = 32'h0000_9000;
    step();
    tlb_miss_i = 1'b0;
    step();
    step();
    #1;
    chk("rst_wait.in_wait", 32'(mem_req_o), 32'd1);
    reset_n = 1'b0;
    #1;
    chk("rst_wait.req_gated",   32'(mem_req_o), 32'd0);
    chk("rst_wait.stall_gated", 32'(stall_o),   32'd0);
    step();
    reset_n = 1'b1; mem_ready_i = 1'b1; mem_data_i = 32'h8000_0055;
    seen_any = 1'b0;
    for (int c = 0; c < 4; c++) begin
      #1;
      if (write_enable_o || page_fault_o || mem_req_o || stall_o) seen_any = 1'b1;
      step();
    end
    mem_ready_i = 1'b0;
    #1;
    chk("rst_wait.no_activity", 32'(seen_any),       32'd0);
    chk("rst_wait.count",       32'(refill_count_o), 32'd0);
    chk("rst_wait.fault_vpn",   32'(fault_vpn_o),    32'd0);

    // Saturation: preload just below the ceiling, then two refills.
    force dut.u_refill_cnt.count_q = 16'hFFFE;
    step();
    release dut.u_refill_cnt.count_q;
    #1;
    chk("sat.preload", 32'(refill_count_o), 32'hFFFE);
    for (int k = 0; k < 2; k++) begin
      tlb_miss_i = 1'b1; virtual_address_i = 32'h0000_1000;
      mem_ready_i = 1'b1; mem_data_i = 32'h8000_0001;
      step();
      tlb_miss_i = 1'b0;
      wait_we($sformatf("sat%0d", k), lat);
      step();
      #1;
      chk($sformatf("sat%0d.count", k), 32'(refill_count_o), 32'hFFFF);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
